spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed.
REQ-002 clk  input  1  SPI serial clock; all state samples on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 SS_n  input  1  slave select, active low; frames one transaction.
REQ-005 MOSI  input  1  serial data from master, MSB first.
REQ-006 MISO  output  1  serial read data to master, MSB first.
REQ-007 rx_data  output  10  assembled command word {cmd[1:0], payload[7:0]} to memory.
REQ-008 rx_valid  output  1  one-cycle strobe, rx_data valid.
REQ-009 tx_data  input  8  read data from memory.
REQ-010 tx_valid  input  1  tx_data valid strobe from memory.

Function
REQ-011 FSM states SHALL be IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA; state register updates on clk rise.
REQ-012 IDLE -> CHK_CMD when SS_n sampled 0; else stay IDLE.
REQ-013 CHK_CMD: SS_n=1 -> IDLE; MOSI=0 -> WRITE; MOSI=1 and rd_pending=0 -> READ_ADD; MOSI=1 and rd_pending=1 -> READ_DATA.
REQ-014 In WRITE/READ_ADD/READ_DATA, the block SHALL shift MOSI into rx_data LSB end, one bit per cycle, for exactly 10 cycles (bit counter 0..9).
REQ-015 rx_valid SHALL be 1 for exactly one cycle, the cycle after the 10th bit is captured; rx_data SHALL hold stable from that cycle until the next frame shifts.
REQ-016 Bits received after the 10th in a frame SHALL be ignored; no second rx_valid in the same frame.
REQ-017 rd_pending SHALL set when a READ_ADD frame raises rx_valid and clear when a READ_DATA frame shifts its last MISO bit.
REQ-018 In READ_DATA after rx_valid, the block SHALL wait for tx_valid=1, latch tx_data, then drive MISO with bit7..bit0 on 8 consecutive cycles starting the cycle after latch.
REQ-019 tx_valid SHALL be ignored in every other state/phase.
REQ-020 MISO SHALL be 0 whenever not shifting read data.
REQ-021 SS_n sampled 1 in any non-IDLE state SHALL return FSM to IDLE next cycle, clear bit counter and MISO shifter, suppress pending rx_valid; rd_pending unchanged.
REQ-022 Back-to-back frames SHALL be supported with SS_n high for one sampled cycle between them.

Reset
REQ-023 rst_n=0 SHALL asynchronously force state=IDLE, rx_data=0, rx_valid=0, MISO=0, rd_pending=0, counters=0.
REQ-024 Reset deassertion mid-frame SHALL leave the block in IDLE until SS_n is next sampled 0.

Configuration
REQ-025 Macro SPI_FRAME_ERR_EN SHALL, when defined, add output frame_err (1 bit, reset 0) pulsing one cycle when SS_n rises before a frame completes (fewer than 10 bits, or READ_DATA before 8 MISO bits); when undefined, the port and logic SHALL be absent and behaviour otherwise identical.

Verification
REQ-026 Write address: SS_n=0, MOSI 0 then 00_1010_0101 -> rx_valid one cycle, rx_data=10'h0A5.
REQ-027 Write data: MOSI 0 then 01_1111_0000 -> rx_data=10'h1F0, rx_valid once, MISO stays 0.
REQ-028 Read sequence: frame 1 then 10_0000_0011 -> rx_data=10'h203, rd_pending=1; frame 1 then 11_xxxx_xxxx, tx_valid with tx_data=8'hC3 -> MISO 1,1,0,0,0,0,1,1, rd_pending=0.
REQ-029 Abort: SS_n high after 5 bits of write frame -> IDLE next cycle, no rx_valid (frame_err=1 pulse with SPI_FRAME_ERR_EN).
REQ-030 Async reset during READ_DATA shifting -> MISO=0, state IDLE, rd_pending=0 immediately, without a clock edge.

Source files
------------

// File: rtl/spi_slave.sv
// SPI slave front end for a small memory.
//
// Receives command frames MSB first on MOSI. A frame is one command-select bit
// followed by ten bits {cmd[1:0], payload[7:0]}. Each completed frame is
// presented on rx_data with a one-cycle rx_valid strobe. A read-data frame
// then waits for tx_valid, latches tx_data and shifts it out on MISO MSB first.
//
// Ports:
//   clk       in   SPI serial clock, all state samples on the rising edge
//   rst_n     in   asynchronous active-low reset
//   SS_n      in   slave select, active low, frames one transaction
//   MOSI      in   serial data from the master
//   MISO      out  serial read data to the master, 0 when idle
//   rx_data   out  assembled command word {cmd, payload}
//   rx_valid  out  one-cycle strobe marking rx_data valid
//   tx_data   in   read data from memory
//   tx_valid  in   tx_data valid strobe from memory
//   frame_err out  only with SPI_FRAME_ERR_EN defined: one-cycle pulse when
//                  SS_n rises before the frame has completed
//
// Optional feature macro: SPI_FRAME_ERR_EN.

module spi_slave (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SS_n,
  input  logic       MOSI,
  output logic       MISO,
  output logic [9:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid
`ifdef SPI_FRAME_ERR_EN
  ,
  output logic       frame_err
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StChkCmd,
    StWrite,
    StReadAdd,
    StReadData
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;   // received payload bits, 0..10
  logic [8:0]  shift_q, shift_d;       // first nine bits of the word in flight
  logic [9:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rd_pending_q, rd_pending_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [3:0]  tx_cnt_q, tx_cnt_d;     // MISO bits launched, 0..8
  logic        miso_q, miso_d;
  logic        frame_done;

`ifdef SPI_FRAME_ERR_EN
  logic        frame_err_q, frame_err_d;
`endif

  // A read-data frame is only complete once all eight MISO bits went out.
  assign frame_done = (bit_cnt_q == 4'd10) &&
                      ((state_q != StReadData) || (tx_cnt_q == 4'd8));

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    rd_pending_d = rd_pending_q;
    tx_shift_d   = tx_shift_q;
    tx_cnt_d     = tx_cnt_q;
    miso_d       = 1'b0;
`ifdef SPI_FRAME_ERR_EN
    frame_err_d  = 1'b0;
`endif

    if (state_q == StIdle) begin
      bit_cnt_d  = 4'd0;
      tx_cnt_d   = 4'd0;
      tx_shift_d = 8'd0;
      if (!SS_n) begin
        state_d = StChkCmd;
      end
    end else if (SS_n) begin
      // Deselect ends the frame: drop any in-flight word, keep rd_pending.
      state_d    = StIdle;
      bit_cnt_d  = 4'd0;
      tx_cnt_d   = 4'd0;
      tx_shift_d = 8'd0;
`ifdef SPI_FRAME_ERR_EN
      frame_err_d = !frame_done;
`endif
    end else begin
      unique case (state_q)
        StChkCmd: begin
          if (!MOSI) begin
            state_d = StWrite;
          end else if (rd_pending_q) begin
            state_d = StReadData;
          end else begin
            state_d = StReadAdd;
          end
        end
        StWrite, StReadAdd, StReadData: begin
          if (bit_cnt_q < 4'd10) begin
            shift_d   = {shift_q[7:0], MOSI};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd9) begin
              rx_data_d  = {shift_q, MOSI};
              rx_valid_d = 1'b1;
              if (state_q == StReadAdd) begin
                rd_pending_d = 1'b1;
              end
            end
          end else if (state_q == StReadData) begin
            if (tx_cnt_q == 4'd0) begin
              if (tx_valid) begin
                miso_d     = tx_data[7];
                tx_shift_d = {tx_data[6:0], 1'b0};
                tx_cnt_d   = 4'd1;
              end
            end else if (tx_cnt_q < 4'd8) begin
              miso_d     = tx_shift_q[7];
              tx_shift_d = {tx_shift_q[6:0], 1'b0};
              tx_cnt_d   = tx_cnt_q + 4'd1;
              // Last bit is now on the wire; the read is consumed.
              if (tx_cnt_q == 4'd7) begin
                rd_pending_d = 1'b0;
              end
            end
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      bit_cnt_q    <= 4'd0;
      shift_q      <= 9'd0;
      rx_data_q    <= 10'd0;
      rx_valid_q   <= 1'b0;
      rd_pending_q <= 1'b0;
      tx_shift_q   <= 8'd0;
      tx_cnt_q     <= 4'd0;
      miso_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rd_pending_q <= rd_pending_d;
      tx_shift_q   <= tx_shift_d;
      tx_cnt_q     <= tx_cnt_d;
      miso_q       <= miso_d;
    end
  end

`ifdef SPI_FRAME_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err = frame_err_q;
`endif

  assign MISO     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

  logic       clk;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
`ifdef SPI_FRAME_ERR_EN
  logic       frame_err;
  int         err_pulses = 0;
`endif

  int vectors     = 0;
  int miscompares = 0;

  logic [9:0] rx_exp_q[$];
  logic       miso_exp_q[$];

  spi_slave dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
`ifdef SPI_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One stimulus cycle: drive on the falling edge, record the MISO value
  // expected right after the following rising edge.
  task automatic step(input logic ss, input logic mosi, input logic tv,
                      input logic [7:0] td, input logic exp_miso);
    @(negedge clk);
    SS_n     = ss;
    MOSI     = mosi;
    tx_valid = tv;
    tx_data  = td;
    miso_exp_q.push_back(exp_miso);
  endtask

  // Select cycle, command-select bit, nbits payload bits from bits[11] down.
  task automatic frame_bits(input logic cmd, input logic [11:0] bits, input int nbits);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, cmd, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < nbits; i++) begin
      step(1'b0, bits[11-i], 1'b0, 8'h00, 1'b0);
    end
  endtask

  task automatic deselect();
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  // Monitor: compare the DUT against the scoreboard queues after each edge.
  initial begin
    logic       exp_bit;
    logic [9:0] exp_word;
    forever begin
      @(posedge clk);
      #1;
      if (miso_exp_q.size() > 0) begin
        exp_bit = miso_exp_q.pop_front();
        check("miso", {9'd0, MISO}, {9'd0, exp_bit});
      end
      if (rx_valid) begin
        if (rx_exp_q.size() == 0) begin
          check("unexpected_rx_valid", 10'd1, 10'd0);
        end else begin
          exp_word = rx_exp_q.pop_front();
          check("rx_data", rx_data, exp_word);
        end
      end
`ifdef SPI_FRAME_ERR_EN
      if (frame_err) err_pulses++;
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] tx_byte;
    rst_n    = 1'b0;
    SS_n     = 1'b1;
    MOSI     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    #3;
    check("reset_rx_data", rx_data, 10'h000);
    check("reset_rx_valid", {9'd0, rx_valid}, 10'd0);
    check("reset_miso", {9'd0, MISO}, 10'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    deselect();

    // Write address 0x0A5, with a stray tx_valid that must be ignored.
    rx_exp_q.push_back(10'h0A5);
    frame_bits(1'b0, {10'h0A5, 2'b00}, 10);
    step(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0);
    deselect();

    // Write data 0x1F0.
    rx_exp_q.push_back(10'h1F0);
    frame_bits(1'b0, {10'h1F0, 2'b00}, 10);
    deselect();

    // Read address 0x203; tx_valid during READ_ADD is ignored.
    rx_exp_q.push_back(10'h203);
    frame_bits(1'b1, {10'h203, 2'b00}, 10);
    step(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    deselect();

    // Read data: 0xC3 shifts out as 1,1,0,0,0,0,1,1.
    tx_byte = 8'hC3;
    rx_exp_q.push_back(10'h300);
    frame_bits(1'b1, {10'h300, 2'b00}, 10);
    step(1'b0, 1'b0, 1'b1, tx_byte, tx_byte[7]);
    for (int i = 6; i >= 0; i--) begin
      step(1'b0, 1'b0, 1'b0, 8'h00, tx_byte[i]);
    end
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    deselect();

    // rd_pending now clear: a '1' frame is a read address, MISO stays low.
    rx_exp_q.push_back(10'h2AA);
    frame_bits(1'b1, {10'h2AA, 2'b00}, 10);
    step(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    deselect();

    // Abort a write after five bits: no rx_valid.
    frame_bits(1'b0, 12'hFFF, 5);
    deselect();

    // Twelve bits: the two after the tenth are ignored, one strobe only.
    rx_exp_q.push_back(10'h155);
    frame_bits(1'b0, {10'h155, 2'b11}, 12);
    deselect();
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    check("rx_data_hold", rx_data, 10'h155);

    // Read data 0xA5 (rd_pending set above), reset asynchronously mid-shift.
    tx_byte = 8'hA5;
    rx_exp_q.push_back(10'h3FF);
    frame_bits(1'b1, {10'h3FF, 2'b00}, 10);
    step(1'b0, 1'b0, 1'b1, tx_byte, tx_byte[7]);
    step(1'b0, 1'b0, 1'b0, 8'h00, tx_byte[6]);
    step(1'b0, 1'b0, 1'b0, 8'h00, tx_byte[5]);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_miso", {9'd0, MISO}, 10'd0);
    check("async_reset_rx_data", rx_data, 10'h000);
    check("async_reset_rx_valid", {9'd0, rx_valid}, 10'd0);
    repeat (2) @(negedge clk);
    SS_n  = 1'b1;
    rst_n = 1'b1;
    deselect();

    // Reset cleared rd_pending: this is a read address, tx_valid ignored.
    rx_exp_q.push_back(10'h3C3);
    frame_bits(1'b1, {10'h3C3, 2'b00}, 10);
    step(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    deselect();
    repeat (3) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

    repeat (3) @(negedge clk);
    check("rx_queue_drained", rx_exp_q.size(), 10'd0);
    check("miso_queue_drained", miso_exp_q.size(), 10'd0);
`ifdef SPI_FRAME_ERR_EN
    check("frame_err_pulses", err_pulses, 10'd1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
